// File: rtl/pattern_sequencer.sv
// Frame-synchronous pattern scheduler: manual index or timed auto-run, changes applied only at frame start.
// Optional build macro PATSEQ_SKIP_MASK_EN: auto-advance skips patterns whose SKIP_MASK bit is set.
module pattern_sequencer #(
    parameter int unsigned NUM_PAT      = 16,
    parameter int unsigned DWELL_FRAMES = 60,
    parameter logic [15:0] SKIP_MASK    = 16'h0000
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       ivsync,
    input  logic       iauto_en,
    input  logic       ipause,
    input  logic [7:0] imanual_idx,
    output logic [7:0] opat_num,
    output logic       oframe_tick,
    output logic       oauto_active,
    output logic [1:0] ostate
);

    localparam int unsigned CNT_W = $clog2(DWELL_FRAMES + 1);
    localparam logic [7:0]       LAST_PAT   = 8'(NUM_PAT - 1);
    localparam logic [CNT_W-1:0] LAST_DWELL = CNT_W'(DWELL_FRAMES - 1);

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_MANUAL = 2'd1,
        S_AUTO   = 2'd2,
        S_PAUSE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_vs_d;
    logic             r_tick;
    logic             r_auto;
    logic [7:0]       r_pat;
    logic [7:0]       w_pat_nxt;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] w_dwell_nxt;
    logic             w_tick;
    logic [7:0]       w_idx_m;

    // Next pattern in auto-run; the masked variant walks forward with wrap in a single tick.
    function automatic logic [7:0] f_advance(input logic [7:0] cur);
`ifdef PATSEQ_SKIP_MASK_EN
        logic [7:0]  res;
        logic        found;
        int unsigned cand;
        res   = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_PAT; k++) begin
            cand = (32'(cur) + k) % NUM_PAT;
            if (!found && !((cand < 32'd16) && SKIP_MASK[cand[3:0]])) begin
                res   = 8'(cand);
                found = 1'b1;
            end
        end
        return res;
`else
        return (cur == LAST_PAT) ? 8'd0 : cur + 8'd1;
`endif
    endfunction

`ifndef PATSEQ_SKIP_MASK_EN
    logic w_unused_skip;
    assign w_unused_skip = ^SKIP_MASK;
`endif

    assign w_tick  = ivsync & ~r_vs_d;
    assign w_idx_m = ({1'b0, imanual_idx} >= 9'(NUM_PAT)) ? LAST_PAT : imanual_idx;

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_state <= S_SYNC;
            r_vs_d  <= 1'b0;
            r_tick  <= 1'b0;
            r_auto  <= 1'b0;
            r_pat   <= 8'd0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vs_d  <= ivsync;
            r_tick  <= w_tick;
            r_auto  <= (w_state_nxt == S_AUTO) || (w_state_nxt == S_PAUSE);
            r_pat   <= w_pat_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    // Inputs are only looked at on the frame-start tick; otherwise everything holds.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_dwell_nxt = r_dwell;
        if (w_tick) begin
            case (r_state)
                S_SYNC: begin
                    w_dwell_nxt = '0;
                    if (iauto_en) begin
                        w_state_nxt = S_AUTO;
                    end else begin
                        w_state_nxt = S_MANUAL;
                        w_pat_nxt   = w_idx_m;
                    end
                end
                S_MANUAL: begin
                    if (iauto_en) begin
                        w_state_nxt = S_AUTO;
                        w_dwell_nxt = '0;
                    end else begin
                        w_pat_nxt = w_idx_m;
                    end
                end
                S_AUTO: begin
                    if (!iauto_en) begin
                        w_state_nxt = S_MANUAL;
                        w_pat_nxt   = w_idx_m;
                    end else if (ipause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (r_dwell == LAST_DWELL) begin
                        w_pat_nxt   = f_advance(r_pat);
                        w_dwell_nxt = '0;
                    end else begin
                        w_dwell_nxt = r_dwell + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (!iauto_en) begin
                        w_state_nxt = S_MANUAL;
                        w_pat_nxt   = w_idx_m;
                    end else if (!ipause) begin
                        w_state_nxt = S_AUTO;
                    end
                end
                default: w_state_nxt = S_SYNC;
            endcase
        end
    end

    assign opat_num     = r_pat;
    assign oframe_tick  = r_tick;
    assign oauto_active = r_auto;
    assign ostate       = r_state;

endmodule
